// File: rtl/dac_link_pkg.sv
// Shared constants and types for the 3-wire DAC link receiver.
// Frame layout: 8-bit control byte followed by a 16-bit data word.
package dac_link_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CTRL_W     = 8;
  localparam int DATA_W     = 16;
  localparam int CH_W       = 2;

  localparam int CTRL_CH_LSB = 1;
  localparam int CTRL_LD_LSB = 4;

  typedef enum logic [1:0] {
    LD_BUF     = 2'b00,
    LD_BUF_UPD = 2'b01,
    LD_UPD_ALL = 2'b10,
    LD_RSVD    = 2'b11
  } ld_e;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/dac_spi_receiver_sync_edge_det.sv
// Two-flop synchronizer plus history flop.
// Edges compare the synchronized value against the history flop.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], d};
      hist_q <= sync_q[1];
    end
  end

  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~hist_q;
  assign fall = ~sync_q[1] & hist_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// Oversampling receiver for the DAC link; rebuilds 24-bit frames and
// models the four-channel DAC buffer and output registers.
module dac_spi_receiver
  import dac_link_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic                   dataclk,
  input  logic                   reset,
  input  logic                   DAC_SYNC,
  input  logic                   DAC_SCLK,
  input  logic                   DAC_DIN,
  input  logic                   rx_en,
  output logic                   word_valid,
  output logic [CTRL_W-1:0]      rx_ctrl,
  output logic [DATA_W-1:0]      rx_data,
  output logic [CH_W-1:0]        rx_channel,
  output logic [DATA_W*N_CH-1:0] dac_out,
  output logic                   frame_err,
  output logic [CNT_W-1:0]       frame_count,
  output logic [CNT_W-1:0]       err_count
);

  logic sync_q, sync_rise, sync_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic din_q, din_rise, din_fall;

  sync_edge_det u_sync (
    .clk  (dataclk),
    .rst  (reset),
    .d    (DAC_SYNC),
    .q    (sync_q),
    .rise (sync_rise),
    .fall (sync_fall)
  );

  sync_edge_det u_sclk (
    .clk  (dataclk),
    .rst  (reset),
    .d    (DAC_SCLK),
    .q    (sclk_q),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge_det u_din (
    .clk  (dataclk),
    .rst  (reset),
    .d    (DAC_DIN),
    .q    (din_q),
    .rise (din_rise),
    .fall (din_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_q, sclk_rise, din_rise, din_fall};

  rx_state_e state_q, state_d;

  logic [FRAME_BITS-1:0] sr_q;
  logic [4:0]            bit_cnt_q;
  logic                  clr, shift_en, done_good, done_bad;

  logic [DATA_W-1:0] dac_buf [N_CH];
  logic [DATA_W-1:0] dac_q   [N_CH];

  logic [DATA_W-1:0] sr_data;
  logic [CH_W-1:0]   sr_ch;
  ld_e               sr_ld;

  assign sr_data = sr_q[DATA_W-1:0];
  assign sr_ch   = sr_q[DATA_W+CTRL_CH_LSB +: CH_W];
  assign sr_ld   = ld_e'(sr_q[DATA_W+CTRL_LD_LSB +: 2]);

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) state_q <= ST_ARM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    shift_en  = 1'b0;
    done_good = 1'b0;
    done_bad  = 1'b0;
    unique case (state_q)
      ST_ARM: begin
        if (sync_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (sync_fall) begin
          clr     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = sclk_fall;
        if (sync_rise) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_good = (bit_cnt_q == 5'(FRAME_BITS));
        done_bad  = ~done_good;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_ARM;
    endcase
    // Disabled receiver re-arms so it never joins a frame mid-way.
    if (!rx_en) begin
      state_d   = ST_ARM;
      clr       = 1'b0;
      shift_en  = 1'b0;
      done_good = 1'b0;
      done_bad  = 1'b0;
    end
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else if (clr) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      sr_q <= {sr_q[FRAME_BITS-2:0], din_q};
      if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
    end
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      word_valid  <= 1'b0;
      frame_err   <= 1'b0;
      rx_ctrl     <= '0;
      rx_data     <= '0;
      rx_channel  <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      word_valid <= done_good;
      frame_err  <= done_bad;
      if (done_good) begin
        rx_ctrl     <= sr_q[FRAME_BITS-1:DATA_W];
        rx_data     <= sr_data;
        rx_channel  <= sr_ch;
        frame_count <= frame_count + 1'b1;
      end
      if (done_bad && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CH; c++) begin
        dac_buf[c] <= '0;
        dac_q[c]   <= '0;
      end
    end else if (done_good) begin
      dac_buf[sr_ch] <= sr_data;
      unique case (sr_ld)
        LD_BUF_UPD: dac_q[sr_ch] <= sr_data;
        LD_UPD_ALL: begin
          for (int c = 0; c < N_CH; c++) begin
            dac_q[c] <= (CH_W'(c) == sr_ch) ? sr_data : dac_buf[c];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dac_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      dac_out[DATA_W*c +: DATA_W] = dac_q[c];
    end
  end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Directed and randomized bench for dac_spi_receiver.
// Frames are driven at minimum link timing from the negative clock edge.
module tb_dac_spi_receiver;

  localparam int N_RAND = 400;

  logic        dataclk = 1'b0;
  logic        reset;
  logic        DAC_SYNC, DAC_SCLK, DAC_DIN, rx_en;
  logic        word_valid, frame_err;
  logic [7:0]  rx_ctrl;
  logic [15:0] rx_data;
  logic [1:0]  rx_channel;
  logic [63:0] dac_out;
  logic [15:0] frame_count, err_count;

  int checks = 0;
  int errors = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  logic [23:0] rxq [$];

  logic [15:0] mbuf [4];
  logic [15:0] mdac [4];

  always #5 dataclk = ~dataclk;

  dac_spi_receiver dut (
    .dataclk     (dataclk),
    .reset       (reset),
    .DAC_SYNC    (DAC_SYNC),
    .DAC_SCLK    (DAC_SCLK),
    .DAC_DIN     (DAC_DIN),
    .rx_en       (rx_en),
    .word_valid  (word_valid),
    .rx_ctrl     (rx_ctrl),
    .rx_data     (rx_data),
    .rx_channel  (rx_channel),
    .dac_out     (dac_out),
    .frame_err   (frame_err),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always @(negedge dataclk) begin
    if (word_valid === 1'b1) begin
      wv_cnt++;
      rxq.push_back({rx_ctrl, rx_data});
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge dataclk);
  endtask

  task automatic send_bits(input logic [31:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      DAC_DIN  = val[i];
      DAC_SCLK = 1'b1;
      wait_clks(2);
      DAC_SCLK = 1'b0;
      wait_clks(2);
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits,
                            input int gap);
    DAC_SYNC = 1'b0;
    wait_clks(1);
    send_bits(val, nbits);
    DAC_SYNC = 1'b1;
    wait_clks(gap);
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      mbuf[c] = '0;
      mdac[c] = '0;
    end
  endtask

  task automatic model_apply(input logic [23:0] v);
    logic [1:0] ld, ch;
    ld = v[21:20];
    ch = v[18:17];
    mbuf[ch] = v[15:0];
    if (ld == 2'b01) mdac[ch] = v[15:0];
    if (ld == 2'b10) for (int c = 0; c < 4; c++) mdac[c] = mbuf[c];
  endtask

  function automatic logic [63:0] model_dac();
    return {mdac[3], mdac[2], mdac[1], mdac[0]};
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    DAC_SYNC = 1'b1;
    DAC_SCLK = 1'b0;
    DAC_DIN  = 1'b0;
    rx_en    = 1'b1;
    wait_clks(3);
    checks++;
    if ({word_valid, frame_err, rx_ctrl, rx_data, rx_channel} !== '0) begin
      errors++;
      $display("FAIL reset_outs got %h/%h/%h/%h exp 0", word_valid,
               rx_ctrl, rx_data, rx_channel);
    end
    checks++;
    if ({dac_out, frame_count, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_regs got %h %h %h exp 0", dac_out,
               frame_count, err_count);
    end
    reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_single();
    int wv0 = wv_cnt;
    send_frame(32'h10_1234, 24, 8);
    checks++;
    if (wv_cnt - wv0 !== 1) begin
      errors++;
      $display("FAIL single_wv got %0d exp 1", wv_cnt - wv0);
    end
    checks++;
    if ({rx_ctrl, rx_data, rx_channel} !== {8'h10, 16'h1234, 2'd0}) begin
      errors++;
      $display("FAIL single_rx got %h %h %h exp 10 1234 0", rx_ctrl,
               rx_data, rx_channel);
    end
    checks++;
    if (dac_out !== 64'h0000_0000_0000_1234) begin
      errors++;
      $display("FAIL single_dac got %h exp 1234", dac_out);
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL single_fc got %0d exp 1", frame_count);
    end
  endtask

  task automatic test_load_cmds();
    send_frame(32'h02_ABCD, 24, 8);
    checks++;
    if (dac_out !== 64'h0000_0000_0000_1234) begin
      errors++;
      $display("FAIL ld00_dac got %h exp 1234", dac_out);
    end
    checks++;
    if (rx_channel !== 2'd1) begin
      errors++;
      $display("FAIL ld00_ch got %0d exp 1", rx_channel);
    end
    send_frame(32'h24_5555, 24, 8);
    checks++;
    if (dac_out !== 64'h0000_5555_ABCD_1234) begin
      errors++;
      $display("FAIL ld10_dac got %h exp 0000_5555_abcd_1234", dac_out);
    end
    checks++;
    if ({rx_channel, frame_count} !== {2'd2, 16'd3}) begin
      errors++;
      $display("FAIL ld10_ch_fc got %0d %0d exp 2 3", rx_channel,
               frame_count);
    end
  endtask

  task automatic test_bad_len();
    int wv0 = wv_cnt;
    int fe0 = fe_cnt;
    send_frame(32'h10_4321, 23, 8);
    send_frame(32'h1_10_4321, 25, 8);
    checks++;
    if (fe_cnt - fe0 !== 2) begin
      errors++;
      $display("FAIL badlen_fe got %0d exp 2", fe_cnt - fe0);
    end
    checks++;
    if (err_count !== 16'd2) begin
      errors++;
      $display("FAIL badlen_ec got %0d exp 2", err_count);
    end
    checks++;
    if (wv_cnt - wv0 !== 0) begin
      errors++;
      $display("FAIL badlen_wv got %0d exp 0", wv_cnt - wv0);
    end
    checks++;
    if ({rx_ctrl, rx_data, frame_count} !== {8'h24, 16'h5555, 16'd3}) begin
      errors++;
      $display("FAIL badlen_hold got %h %h %0d exp 24 5555 3", rx_ctrl,
               rx_data, frame_count);
    end
    checks++;
    if (dac_out !== 64'h0000_5555_ABCD_1234) begin
      errors++;
      $display("FAIL badlen_dac got %h exp 0000_5555_abcd_1234", dac_out);
    end
  endtask

  task automatic test_reset_mid_frame();
    int wv0, fe0;
    DAC_SYNC = 1'b0;
    wait_clks(1);
    send_bits(32'h10_3C3C >> 14, 10);
    reset = 1'b1;
    wv0 = wv_cnt;
    fe0 = fe_cnt;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(2);
    send_bits(32'h10_3C3C, 14);
    DAC_SYNC = 1'b1;
    wait_clks(8);
    send_frame(32'h10_00FF, 24, 8);
    checks++;
    if (dac_out !== 64'h0000_0000_0000_00FF) begin
      errors++;
      $display("FAIL rstmid_dac got %h exp 00ff", dac_out);
    end
    checks++;
    if ({frame_count, err_count} !== {16'd1, 16'd0}) begin
      errors++;
      $display("FAIL rstmid_cnt got %0d %0d exp 1 0", frame_count,
               err_count);
    end
    checks++;
    if ({wv_cnt - wv0, fe_cnt - fe0} !== {32'd1, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_pulses got %0d %0d exp 1 0", wv_cnt - wv0,
               fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] sent [N_RAND];
    int base;
    reset = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(4);
    model_reset();
    base = rxq.size();
    for (int i = 0; i < N_RAND; i++) begin
      sent[i] = 24'($urandom);
      model_apply(sent[i]);
      send_frame({8'h00, sent[i]}, 24, 2);
    end
    wait_clks(8);
    checks++;
    if (rxq.size() - base !== N_RAND) begin
      errors++;
      $display("FAIL b2b_words got %0d exp %0d", rxq.size() - base, N_RAND);
    end
    for (int i = 0; i < N_RAND; i++) begin
      if (base + i < rxq.size()) begin
        checks++;
        if (rxq[base + i] !== sent[i]) begin
          errors++;
          $display("FAIL b2b_word%0d got %h exp %h", i, rxq[base + i],
                   sent[i]);
        end
      end
    end
    checks++;
    if ({frame_count, err_count} !== {16'(N_RAND), 16'd0}) begin
      errors++;
      $display("FAIL b2b_cnt got %0d %0d exp %0d 0", frame_count,
               err_count, N_RAND);
    end
    checks++;
    if (dac_out !== model_dac()) begin
      errors++;
      $display("FAIL b2b_dac got %h exp %h", dac_out, model_dac());
    end
  endtask

  task automatic test_rx_en();
    int wv0 = wv_cnt;
    int fe0 = fe_cnt;
    rx_en = 1'b0;
    wait_clks(2);
    send_frame(32'h10_7777, 24, 8);
    checks++;
    if ({wv_cnt - wv0, fe_cnt - fe0} !== {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL rxen_pulses got %0d %0d exp 0 0", wv_cnt - wv0,
               fe_cnt - fe0);
    end
    checks++;
    if (dac_out !== model_dac()) begin
      errors++;
      $display("FAIL rxen_hold got %h exp %h", dac_out, model_dac());
    end
    checks++;
    if (frame_count !== 16'(N_RAND)) begin
      errors++;
      $display("FAIL rxen_fc got %0d exp %0d", frame_count, N_RAND);
    end
    rx_en = 1'b1;
    wait_clks(6);
    model_apply(24'h10_8888);
    send_frame(32'h10_8888, 24, 8);
    checks++;
    if (dac_out[15:0] !== 16'h8888 || dac_out !== model_dac()) begin
      errors++;
      $display("FAIL rxen_resume got %h exp %h", dac_out, model_dac());
    end
    checks++;
    if (frame_count !== 16'(N_RAND + 1)) begin
      errors++;
      $display("FAIL rxen_fc2 got %0d exp %0d", frame_count, N_RAND + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_load_cmds();
    test_bad_len();
    test_reset_mid_frame();
    test_back_to_back();
    test_rx_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
